// File: rtl/buzzer_arbiter_if.sv
// Request/response bundle between the sound requesters and the buzzer arbiter.
// master = requester side (drives enable/req), slave = arbiter side.
interface buzzer_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic             buzzer_out;
  logic             busy;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  active_id;

  modport master (
    output enable, req,
    input  buzzer_out, busy, grant, active_id
  );

  modport slave (
    input  enable, req,
    output buzzer_out, busy, grant, active_id
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer sharing: latches requests, plays one fixed-length square-wave
// tone per grant at the winner's pitch, then a silent gap; optional preemption.
module buzzer_arbiter #(
  parameter int                  N_REQ       = 4,
  parameter logic [20*N_REQ-1:0] HALF_TABLE  = {20'd37_922, 20'd47_778, 20'd50_619, 20'd56_818},
  parameter int                  TONE_CYCLES = 5_000_000,
  parameter int                  GAP_CYCLES  = 1_000_000,
  parameter bit                  PREEMPT     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  buzzer_arbiter_if.slave    bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DUR_W = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(TONE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_reg,   state_next;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic [19:0]      half_cnt_reg, half_cnt_next;
  logic [DUR_W-1:0] dur_cnt_reg, dur_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             buzz_reg,    buzz_next;
  logic [N_REQ-1:0] grant_reg,   grant_next;
  logic [ID_W-1:0]  active_reg,  active_next;

  logic [19:0]      half_tab [N_REQ];
  logic [19:0]      half_sel;
  logic [ID_W-1:0]  winner;
  logic [N_REQ-1:0] winner_onehot;
  logic [N_REQ-1:0] above_mask;
  logic             preempt_hit;
  logic             do_grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : gen_tables
      assign half_tab[gi]      = HALF_TABLE[20*gi +: 20];
      assign winner_onehot[gi] = (winner == ID_W'(gi));
      // Requesters with strictly higher priority than the one now playing.
      assign above_mask[gi]    = (ID_W'(gi) < active_reg);
    end
  endgenerate

  assign half_sel    = half_tab[active_reg];
  assign preempt_hit = |(pending_reg & above_mask);

  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_reg[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      half_cnt_reg <= '0;
      dur_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      buzz_reg     <= 1'b0;
      grant_reg    <= '0;
      active_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      half_cnt_reg <= half_cnt_next;
      dur_cnt_reg  <= dur_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      buzz_reg     <= buzz_next;
      grant_reg    <= grant_next;
      active_reg   <= active_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    dur_cnt_next  = dur_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    buzz_next     = buzz_reg;
    grant_next    = '0;
    active_next   = active_reg;
    do_grant      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|pending_reg) do_grant = 1'b1;
      end
      PLAY: begin
        if (PREEMPT && preempt_hit) begin
          do_grant = 1'b1;
        end else begin
          if (half_cnt_reg == half_sel - 20'd1) begin
            buzz_next     = ~buzz_reg;
            half_cnt_next = '0;
          end else begin
            half_cnt_next = half_cnt_reg + 20'd1;
          end
          if (dur_cnt_reg == '0) begin
            buzz_next = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_next   = GAP;
              gap_cnt_next = GAP_LOAD;
            end else begin
              state_next = IDLE;
            end
          end else begin
            dur_cnt_next = dur_cnt_reg - 1'b1;
          end
        end
      end
      GAP: begin
        buzz_next = 1'b0;
        if (gap_cnt_reg == '0) state_next = IDLE;
        else                   gap_cnt_next = gap_cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (do_grant) begin
      state_next    = PLAY;
      active_next   = winner;
      grant_next    = winner_onehot;
      buzz_next     = 1'b1;
      half_cnt_next = '0;
      dur_cnt_next  = DUR_LOAD;
    end

    // A new request on the granting edge re-arms the bit, so set beats clear.
    pending_next = (pending_reg & ~grant_next) | (bus.req & {N_REQ{bus.enable}});

    if (!bus.enable) begin
      state_next   = IDLE;
      pending_next = '0;
      buzz_next    = 1'b0;
      grant_next   = '0;
      active_next  = active_reg;
    end
  end

  assign bus.buzzer_out = buzz_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.grant      = grant_reg;
  assign bus.active_id  = active_reg;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: per-cycle expected outputs are queued with the stimulus
// and compared at each falling clock edge; a second instance runs without preemption.
module tb_buzzer_arbiter;

  localparam int          N_REQ = 4;
  localparam logic [79:0] HT    = {20'd5, 20'd4, 20'd3, 20'd2};
  localparam int          TONE  = 20;
  localparam int          GAPC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buzzer_arbiter_if #(.N_REQ(N_REQ)) bus_p ();
  buzzer_arbiter_if #(.N_REQ(N_REQ)) bus_n ();

  buzzer_arbiter #(
    .N_REQ(N_REQ), .HALF_TABLE(HT), .TONE_CYCLES(TONE), .GAP_CYCLES(GAPC), .PREEMPT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_p)
  );

  buzzer_arbiter #(
    .N_REQ(N_REQ), .HALF_TABLE(HT), .TONE_CYCLES(TONE), .GAP_CYCLES(GAPC), .PREEMPT(1'b0)
  ) dut_np (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  typedef struct {
    logic       buzz;
    logic       busy;
    logic [3:0] grant;
    logic [1:0] id;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] req;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc_idx = 0;
  string test_name = "reset";
  logic [1:0] last_id = 2'd0;
  int    half_of[4] = '{2, 3, 4, 5};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s/%s cycle %0d: observed %0h expected %0h", test_name, tag, cyc_idx, obs, expv);
    end
  endtask

  task automatic push_stim(input logic en, input logic [3:0] r, input int n);
    stim_t s;
    s.en  = en;
    s.req = r;
    repeat (n) stim_q.push_back(s);
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e.buzz  = 1'b0;
    e.busy  = 1'b0;
    e.grant = 4'b0000;
    e.id    = last_id;
    repeat (n) exp_q.push_back(e);
  endtask

  // One tone as the spec describes it: high for HALF cycles, low for HALF, ...; grant on cycle 0.
  task automatic push_tone(input int id, input int ncyc, input bit with_gap);
    exp_t e;
    int   half;
    half    = half_of[id];
    last_id = 2'(id);
    for (int t = 0; t < ncyc; t++) begin
      e.buzz  = ((t / half) % 2 == 0);
      e.busy  = 1'b1;
      e.grant = (t == 0) ? (4'b0001 << id) : 4'b0000;
      e.id    = 2'(id);
      exp_q.push_back(e);
    end
    if (with_gap) begin
      for (int g = 0; g < GAPC; g++) begin
        e.buzz  = 1'b0;
        e.busy  = 1'b1;
        e.grant = 4'b0000;
        e.id    = 2'(id);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input bit use_np);
    exp_t  e;
    stim_t s;
    cyc_idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (use_np) begin
        chk("buzzer_out", {7'd0, bus_n.buzzer_out}, {7'd0, e.buzz});
        chk("busy",       {7'd0, bus_n.busy},       {7'd0, e.busy});
        chk("grant",      {4'd0, bus_n.grant},      {4'd0, e.grant});
        chk("active_id",  {6'd0, bus_n.active_id},  {6'd0, e.id});
      end else begin
        chk("buzzer_out", {7'd0, bus_p.buzzer_out}, {7'd0, e.buzz});
        chk("busy",       {7'd0, bus_p.busy},       {7'd0, e.busy});
        chk("grant",      {4'd0, bus_p.grant},      {4'd0, e.grant});
        chk("active_id",  {6'd0, bus_p.active_id},  {6'd0, e.id});
      end
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
      end else begin
        s.en  = 1'b1;
        s.req = 4'b0000;
      end
      if (use_np) begin
        bus_n.enable = s.en;
        bus_n.req    = s.req;
      end else begin
        bus_p.enable = s.en;
        bus_p.req    = s.req;
      end
      cyc_idx++;
    end
    stim_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_p.enable = 1'b1;
    bus_p.req    = 4'b0000;
    bus_n.enable = 1'b1;
    bus_n.req    = 4'b0000;
    rst          = 1'b1;

    repeat (2) @(negedge clk);
    test_name = "reset";
    chk("buzzer_out", {7'd0, bus_p.buzzer_out}, 8'd0);
    chk("busy",       {7'd0, bus_p.busy},       8'd0);
    chk("grant",      {4'd0, bus_p.grant},      8'd0);
    chk("active_id",  {6'd0, bus_p.active_id},  8'd0);
    chk("np_busy",    {7'd0, bus_n.busy},       8'd0);
    rst = 1'b0;

    test_name = "single_id0";
    push_stim(1'b1, 4'b0001, 1);
    push_idle(2);
    push_tone(0, TONE, 1'b1);
    push_idle(1);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "two_same_cycle";
    push_stim(1'b1, 4'b1010, 1);
    push_idle(2);
    push_tone(1, TONE, 1'b1);
    push_idle(1);
    push_tone(3, TONE, 1'b1);
    push_idle(1);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "preempt";
    push_stim(1'b1, 4'b0100, 1);
    push_stim(1'b1, 4'b0000, 8);
    push_stim(1'b1, 4'b0001, 1);
    push_idle(2);
    push_tone(2, 9, 1'b0);
    push_tone(0, TONE, 1'b1);
    push_idle(1);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "no_preempt";
    last_id = 2'd0;
    push_stim(1'b1, 4'b0100, 1);
    push_stim(1'b1, 4'b0000, 8);
    push_stim(1'b1, 4'b0001, 1);
    push_idle(2);
    push_tone(2, TONE, 1'b1);
    push_idle(1);
    push_tone(0, TONE, 1'b1);
    push_idle(1);
    run(1'b1);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "held_repeat";
    last_id = 2'd0;
    push_stim(1'b1, 4'b0010, 30);
    push_idle(2);
    push_tone(1, TONE, 1'b1);
    push_idle(1);
    push_tone(1, TONE, 1'b1);
    push_idle(1);
    push_tone(1, TONE, 1'b1);
    push_idle(3);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "enable_drop";
    push_stim(1'b1, 4'b0010, 1);
    push_stim(1'b1, 4'b0000, 4);
    push_stim(1'b1, 4'b0100, 1);
    push_stim(1'b1, 4'b0000, 3);
    push_stim(1'b0, 4'b0000, 1);
    push_stim(1'b0, 4'b1111, 3);
    push_stim(1'b1, 4'b0000, 1);
    push_idle(2);
    push_tone(1, 8, 1'b0);
    push_idle(8);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    test_name = "async_reset";
    push_stim(1'b1, 4'b1000, 1);
    push_idle(2);
    push_tone(3, 4, 1'b0);
    run(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("buzzer_out", {7'd0, bus_p.buzzer_out}, 8'd0);
    chk("busy",       {7'd0, bus_p.busy},       8'd0);
    chk("grant",      {4'd0, bus_p.grant},      8'd0);
    chk("active_id",  {6'd0, bus_p.active_id},  8'd0);
    @(negedge clk);
    rst = 1'b0;
    last_id = 2'd0;
    push_idle(3);
    run(1'b0);
    $display("test %s done: %0d compared / %0d bad so far", test_name, n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
